mem_initiator: RTL
==================

# mem_initiator

Single-outstanding bus initiator that drives the native memory bus (mem_valid / mem_addr / mem_wdata / mem_wstrb, mem_ready / mem_rdata) that our memory-mapped peripherals respond on, including the GPIO block. It accepts one command at a time on a valid/ready command port, runs exactly one bus transfer, and returns read data plus an error flag on a valid/ready response port. It sits between a test/debug controller (or host bridge) and the peripheral bus, so peripherals can be exercised without a CPU.

## Interface
- TIMEOUT, 255: bus-wait limit in cycles; valid range 1..65535; used only when MEM_INITIATOR_TIMEOUT_EN is defined.
- clk  in  1  sole clock; all logic on posedge.
- resetn  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte enables; 4'b0000 = read, non-zero = write.
- mem_valid  out  1  bus request.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_wstrb  out  4  bus byte enables (0 for reads).
- mem_ready  in  1  responder completes transfer on a cycle where mem_valid && mem_ready.
- mem_rdata  in  32  responder read data, valid with mem_ready.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  captured read data (0 for writes and errors).
- rsp_err  out  1  1 = misaligned command or bus timeout.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: cmd_ready=1, mem_valid=0, rsp_valid=0. On cmd handshake, register addr/wdata/wstrb.
  - cmd_addr[1:0] != 0: go to RESP with rsp_err=1, rsp_rdata=0; no bus access.
  - otherwise go to REQ.
- REQ: mem_valid=1; mem_addr/mem_wdata/mem_wstrb held constant from registered command until completion. cmd_ready=0.
  - mem_ready=1: capture mem_rdata into rsp_rdata if read (wstrb==0), else rsp_rdata=0; rsp_err=0; go to RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; cmd_ready=0. On rsp_ready go to IDLE.
- One outstanding command; no pipelining, no command buffering.
- mem_addr, mem_wdata, mem_wstrb are 0 whenever mem_valid=0.
- Reset (resetn=0 at a posedge), from any state including mid-REQ: state=IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0 during reset cycle, 1 the first cycle after reset released. In-flight command dropped, no response issued.

## Timing
- Cmd handshake at cycle N -> mem_valid=1 at N+1.
- Zero-wait responder (mem_ready tied 1): completion at N+1, rsp_valid=1 at N+2; rsp_ready=1 at N+2 -> cmd_ready=1 at N+3. Peak throughput: one command per 3 cycles.
- Wait states: mem_valid stays high, request fields unchanged, until mem_ready sampled high; rsp_valid rises the cycle after.
- Misaligned command at N -> rsp_valid=1, rsp_err=1 at N+1; mem_valid never asserts.
- rsp_valid held with rsp_ready=0 indefinitely: outputs stable, no new command accepted.
- mem_ready while mem_valid=0 is ignored.

## Configuration
- MEM_INITIATOR_TIMEOUT_EN defined: 16-bit wait counter cleared on entry to REQ, increments each REQ cycle with mem_ready=0. When counter == TIMEOUT and mem_ready=0, the transfer is abandoned: mem_valid drops next cycle, RESP entered with rsp_err=1, rsp_rdata=0. mem_ready=1 on the same cycle the limit is hit wins (normal completion).
- Not defined: no counter; REQ waits forever for mem_ready; rsp_err set only for misalignment.

## Test plan
- Write: cmd addr=0x1000_0000, wdata=0x0000_00A5, wstrb=4'b0001, mem_ready=1 -> one cycle of mem_valid with exact fields; rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
- Read with wait states: cmd addr=0x1000_0004, wstrb=0; mem_ready low 3 cycles then high with mem_rdata=0x0000_005C -> mem_valid high exactly 4 cycles, fields stable; rsp_rdata=0x0000_005C, rsp_err=0.
- Misaligned: cmd addr=0x1000_0002 -> no mem_valid; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Response backpressure: rsp_ready=0 for 5 cycles while cmd_valid=1 -> cmd_ready=0 and rsp fields stable throughout; second command accepted the cycle after rsp_ready handshake.
- Reset mid-REQ: resetn=0 during a waiting read -> next cycle mem_valid=0, rsp_valid=0, all outputs 0; after release cmd_ready=1 and no stale response appears.
- With MEM_INITIATOR_TIMEOUT_EN, TIMEOUT=4, mem_ready tied 0 -> mem_valid high for 5 cycles, then rsp_err=1, rsp_rdata=0; without macro, mem_valid stays high for 1000 cycles and no response.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator
// Single-outstanding initiator for the native memory bus. Takes one command on
// a valid/ready command port, performs exactly one bus transfer, and returns
// read data plus an error flag on a valid/ready response port.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_addr/cmd_wdata/cmd_wstrb   command fields (wstrb == 0 means read)
//   mem_valid/mem_addr/mem_wdata/mem_wstrb  bus request (fields 0 when idle)
//   mem_ready/mem_rdata            bus completion and read data
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              read data (0 for writes/errors), error flag
//
// Parameters:
//   TIMEOUT  bus-wait limit in cycles (1..65535), only used when the
//            MEM_INITIATOR_TIMEOUT_EN macro is defined.
//
// Optional feature: define MEM_INITIATOR_TIMEOUT_EN to abandon a transfer
// that waits TIMEOUT cycles without mem_ready; the response then carries
// rsp_err=1. Without it the initiator waits indefinitely.

module mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // Reject an out-of-range limit at elaboration time.
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("mem_initiator: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout_s;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  assign timeout_s = (wait_cnt_q == TIMEOUT_C);

  // Wait counter: held at zero outside REQ so it starts from zero on entry,
  // counts REQ cycles in which the responder has not completed.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != REQ) begin
      wait_cnt_d = 16'd0;
    end else if (!mem_ready) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt_q <= 16'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered so the bus
  // and response ports are glitch-free.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        // cmd_ready_q is low for the first cycle after reset, so no command
        // can be taken until it has risen.
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_addr_d  = cmd_addr;
            mem_wdata_d = cmd_wdata;
            mem_wstrb_d = cmd_wstrb;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      REQ: begin
        // A completion on the same cycle the limit is reached takes priority.
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wdata_d = 32'h0000_0000;
          mem_wstrb_d = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (mem_wstrb_q == 4'b0000) begin
            rsp_rdata_d = mem_rdata;
          end else begin
            rsp_rdata_d = 32'h0000_0000;
          end
        end else if (timeout_s) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wdata_d = 32'h0000_0000;
          mem_wstrb_d = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        mem_valid_d = 1'b0;
        mem_addr_d  = 32'h0000_0000;
        mem_wdata_d = 32'h0000_0000;
        mem_wstrb_d = 4'b0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
